imem_loader: RTL and testbench

//   Program loader for the pipeline CPU's instruction memory: the write side of the IM port the

---
 rtl/imem_loader.sv | 195 +++++++++++++++++++
 tb/tb_imem_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory program loader: assembles a little-endian byte stream into 32-bit IM writes
// and holds the CPU until the image is complete. Define IMEM_LOADER_CHECKSUM_EN for a trailing checksum word.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  load_start_i,
    input  logic [ADDR_WIDTH:0]   load_count_i,
    input  logic [7:0]            s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic                  im_we_o,
    output logic [ADDR_WIDTH-1:0] im_addr_o,
    output logic [31:0]           im_wdata_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   word_idx_q;
    logic [1:0]            byte_idx_q;
    logic [31:0]           word_q;
    logic                  s_ready_q;
    logic                  im_we_q;
    logic [ADDR_WIDTH-1:0] im_addr_q;
    logic [31:0]           im_wdata_q;
    logic                  cpu_hold_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]           sum_q;
    logic                  hold_err_q;
`endif

    logic [31:0] word_d;
    logic        accept_s;
    logic        word_done_s;
    logic        last_word_s;
    logic        count_ok_s;

    // Merge the incoming byte into its lane and decode the stream/count conditions.
    always_comb begin
        word_d      = word_q;
        accept_s    = s_valid_i && s_ready_q;
        case (byte_idx_q)
            2'd0:    word_d[7:0]   = s_data_i;
            2'd1:    word_d[15:8]  = s_data_i;
            2'd2:    word_d[23:16] = s_data_i;
            2'd3:    word_d[31:24] = s_data_i;
            default: word_d        = word_q;
        endcase
        if (accept_s && (byte_idx_q == 2'd3)) begin
            word_done_s = 1'b1;
        end else begin
            word_done_s = 1'b0;
        end
        last_word_s = ((word_idx_q + ONE) == count_q);
        if ((load_count_i != {(ADDR_WIDTH+1){1'b0}}) && (load_count_i <= DEPTH)) begin
            count_ok_s = 1'b1;
        end else begin
            count_ok_s = 1'b0;
        end
    end

    // Loader FSM with all outputs registered.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            count_q    <= {(ADDR_WIDTH+1){1'b0}};
            word_idx_q <= {(ADDR_WIDTH+1){1'b0}};
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
            s_ready_q  <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= {ADDR_WIDTH{1'b0}};
            im_wdata_q <= 32'd0;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= 32'd0;
            hold_err_q <= 1'b0;
`endif
        end else begin
            im_we_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start_i && count_ok_s) begin
                        count_q    <= load_count_i;
                        word_idx_q <= {(ADDR_WIDTH+1){1'b0}};
                        byte_idx_q <= 2'd0;
                        word_q     <= 32'd0;
                        error_q    <= 1'b0;
                        s_ready_q  <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q      <= 32'd0;
                        hold_err_q <= 1'b0;
`endif
                    end else if (load_start_i) begin
                        error_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (accept_s) begin
                        word_q     <= word_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                    end
                    if (word_done_s) begin
                        im_we_q    <= 1'b1;
                        im_addr_q  <= word_idx_q[ADDR_WIDTH-1:0];
                        im_wdata_q <= word_d;
                        word_idx_q <= word_idx_q + ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q      <= sum_q + word_d;
                        if (last_word_s) begin
                            state_q <= ST_CHECK;
                        end
`else
                        if (last_word_s) begin
                            s_ready_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                // The trailing word is the expected sum; it is compared, never written to IM.
                ST_CHECK: begin
                    if (accept_s) begin
                        word_q     <= word_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                    end
                    if (word_done_s) begin
                        s_ready_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                        if (word_d != sum_q) begin
                            error_q    <= 1'b1;
                            hold_err_q <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    cpu_hold_q <= hold_err_q;
`else
                    cpu_hold_q <= 1'b0;
`endif
                end
                default: begin
                    s_ready_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    cpu_hold_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready_o  = s_ready_q;
    assign im_we_o    = im_we_q;
    assign im_addr_o  = im_addr_q;
    assign im_wdata_o = im_wdata_q;
    assign cpu_hold_o = cpu_hold_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads plus random images compared against a
// word-list model of what IM should receive.
module tb_imem_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic [AW:0]   load_count = '0;
    logic [7:0]    s_data = 8'd0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    logic [31:0]   image[$];
    bit            ready_dropped;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .load_start_i(load_start),
        .load_count_i(load_count),
        .s_data_i    (s_data),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .im_we_o     (im_we),
        .im_addr_o   (im_addr),
        .im_wdata_o  (im_wdata),
        .cpu_hold_o  (cpu_hold),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (im_we === 1'b1) begin
            got_addr.push_back(im_addr);
            got_data.push_back(im_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input int n);
        load_start = 1'b1;
        load_count = (AW+1)'(n);
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit acc;
        bit sent;
        if (gap) begin
            s_valid = 1'b0;
            tick();
            if (s_ready !== 1'b1) ready_dropped = 1'b1;
        end
        s_data  = b;
        s_valid = 1'b1;
        sent    = 1'b0;
        for (int k = 0; k < 16 && !sent; k++) begin
            acc = (s_ready === 1'b1);
            tick();
            if (acc) sent = 1'b1;
        end
        s_valid = 1'b0;
        if (!sent) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_pct);
        logic [31:0] t;
        for (int b = 0; b < 4; b++) begin
            t = w >> (8 * b);
            send_byte(t[7:0], $urandom_range(99) < gap_pct);
        end
    endtask

    // Loads the current image; the model expects word i at address i and a release afterwards.
    task automatic run_load(input int gap_pct, input bit poke, input bit bad_sum);
        int          n;
        logic [31:0] sum;
        n   = image.size();
        sum = 32'd0;
        got_addr.delete();
        got_data.delete();
        ready_dropped = 1'b0;
        pulse_start(n);
        check("start_hold",  32'(cpu_hold), 32'd1);
        check("start_busy",  32'(busy),     32'd1);
        check("start_ready", 32'(s_ready),  32'd1);
        check("start_error", 32'(error),    32'd0);
        for (int w = 0; w < n; w++) begin
            send_word(image[w], gap_pct);
            sum = sum + image[w];
            if (poke && w == 0) begin
                load_start = 1'b1;
                load_count = '0;
                tick();
                load_start = 1'b0;
            end
        end
        check("last_we",   32'(im_we),   32'd1);
        check("last_addr", 32'(im_addr), 32'(n - 1));
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("done_before_sum", 32'(done), 32'd0);
        send_word(bad_sum ? 32'd0 : sum, gap_pct);
        check("sum_done", 32'(done),  32'd1);
        check("sum_we",   32'(im_we), 32'd0);
`else
        check("last_done", 32'(done), 32'd1);
`endif
        check("done_hold", 32'(cpu_hold), 32'd1);
        tick();
        check("rel_hold",  32'(cpu_hold), bad_sum ? 32'd1 : 32'd0);
        check("rel_busy",  32'(busy),     32'd0);
        check("rel_done",  32'(done),     32'd0);
        check("rel_we",    32'(im_we),    32'd0);
        check("rel_error", 32'(error),    bad_sum ? 32'd1 : 32'd0);
        check("ready_gaps", 32'(ready_dropped), 32'd0);
        check("n_writes", 32'(got_addr.size()), 32'(n));
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            check($sformatf("addr[%0d]", i), 32'(got_addr[i]), 32'(i));
            check($sformatf("data[%0d]", i), got_data[i], image[i]);
        end
    endtask

    initial begin
        // Reset: every output low.
        reset = 1'b1;
        tick();
        tick();
        check("rst_ready", 32'(s_ready),  32'd0);
        check("rst_we",    32'(im_we),    32'd0);
        check("rst_addr",  32'(im_addr),  32'd0);
        check("rst_wdata", im_wdata,      32'd0);
        check("rst_hold",  32'(cpu_hold), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_error", 32'(error),    32'd0);
        reset = 1'b0;
        tick();

        // Two-word image back-to-back, then with gaps and an ignored mid-load start.
        image = '{32'h00430820, 32'h00a62023};
        run_load(0, 1'b0, 1'b0);
        run_load(100, 1'b1, 1'b0);

        // Illegal counts.
        got_addr.delete();
        pulse_start(0);
        check("cnt0_error", 32'(error),    32'd1);
        check("cnt0_busy",  32'(busy),     32'd0);
        check("cnt0_hold",  32'(cpu_hold), 32'd0);
        check("cnt0_ready", 32'(s_ready),  32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse_start(DEPTH + 1);
        check("cntmax_error", 32'(error),    32'd1);
        check("cntmax_busy",  32'(busy),     32'd0);
        check("cntmax_hold",  32'(cpu_hold), 32'd0);
        tick();
        tick();
        check("illegal_no_we", 32'(got_addr.size()), 32'd0);

        // Full-depth image clears the error and reaches the top address.
        image.delete();
        for (int i = 0; i < DEPTH; i++) image.push_back($urandom);
        run_load(0, 1'b0, 1'b0);

        // Reset part-way through word 0, then a one-word load.
        got_addr.delete();
        pulse_start(2);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_hold",  32'(cpu_hold), 32'd0);
        check("midrst_busy",  32'(busy),     32'd0);
        check("midrst_ready", 32'(s_ready),  32'd0);
        tick();
        tick();
        check("midrst_no_we", 32'(got_addr.size()), 32'd0);
        image = '{32'h8c0f0008};
        run_load(0, 1'b0, 1'b0);

        // Random images with random valid gaps.
        for (int r = 0; r < 6; r++) begin
            image.delete();
            for (int i = 0; i < int'($urandom_range(12, 1)); i++) image.push_back($urandom);
            run_load(int'($urandom_range(60)), 1'b0, 1'b0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum keeps the CPU held until reset or a new valid load.
        image = '{32'h00430820, 32'h00a62023};
        run_load(0, 1'b0, 1'b1);
        tick();
        tick();
        check("bad_hold_idle", 32'(cpu_hold), 32'd1);
        pulse_start(0);
        check("bad_hold_illegal", 32'(cpu_hold), 32'd1);
        run_load(30, 1'b0, 1'b0);
        run_load(0, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("bad_hold_reset", 32'(cpu_hold), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
